fc_backward_update: RTL and testbench
=====================================

# fc_backward_update

Backward-pass and weight-update engine for one fully connected neuron, the reverse direction of the forward FMA-chain layer. Given the neuron's output error `delta`, it computes the input gradient `input_grad[i] = weight[i] * delta` for propagation to the previous layer. It also computes the SGD-updated weights `weight_out[i] = weight[i] - learning_rate * delta * input_data[i]`. It processes one element per cycle with two shared `fma #(15,32)` instances and sits beside the forward layer in the training datapath.

## Interface
- `INPUT_SIZE`, default 32: number of inputs/weights; must be ≥ 2. Index counter width is `$clog2(INPUT_SIZE)`.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request to run one backward/update pass; sampled only in IDLE.
- `delta` input 32: fp32 output error; captured on the accepted `start` edge.
- `learning_rate` input 32: fp32 positive step size; captured on the accepted `start` edge.
- `input_data` input 32 × `[INPUT_SIZE-1:0]`: fp32 forward-pass activations; must be held stable from `start` until `done`.
- `weight` input 32 × `[INPUT_SIZE-1:0]`: fp32 current weights; must be held stable from `start` until `done`.
- `weight_out` output 32 × `[INPUT_SIZE-1:0]`: registered fp32 updated weights.
- `input_grad` output 32 × `[INPUT_SIZE-1:0]`: registered fp32 gradients toward the previous layer.
- `busy` output 1: high in SCALE and UPDATE.
- `done` output 1: one-cycle pulse when the pass completes.

## Operation
- **FSM states:** IDLE, SCALE, UPDATE, DONE.
- **IDLE:**
  - On `start`=1, latch `delta` into `delta_q` and `learning_rate` into `lr_q`, clear `idx` to 0, and go to SCALE.
  - `start`=0 stays in IDLE.
- **SCALE:**
  - One cycle. Compute `neg_step = fma(a=0, b={~lr_q[31], lr_q[30:0]}, c=delta_q)`.
  - The sign flip is an exact bit-31 inversion; no subtract hardware is used.
  - Register `neg_step` and go to UPDATE.
- **UPDATE:** each cycle, for element `idx`:
  - `input_grad[idx] <= fma(a=0, b=weight[idx], c=delta_q)`.
  - `weight_out[idx] <= fma(a=weight[idx], b=neg_step, c=input_data[idx])`.
  - `idx` increments by 1. When `idx == INPUT_SIZE-1`, write the last element, clear `idx` to 0, and go to DONE.
- **DONE:** one cycle with `done`=1, then return to IDLE.
- **Arithmetic:** all arithmetic goes through the team `fma #(15,32)` module (result = a + b·c, fp32). Its rounding, overflow and NaN behaviour is inherited unchanged; this block adds no special-case handling.
- **Shared resources:** both FMA instances are time-multiplexed across all indices. The SCALE step reuses the gradient instance through a mux on its operands.
- **Writes:** only the element addressed by `idx` is written in a cycle; all other `weight_out`/`input_grad` entries hold their values.
- **`start` while busy:** `start` asserted in SCALE, UPDATE or DONE is ignored. It is not queued, and `delta_q`/`lr_q` do not change.
- **Back-to-back passes:** `start` held high through DONE is accepted on the first IDLE cycle after it.
- **Reset mid-operation:** `rst_n`=0 at any time forces IDLE immediately. It clears `idx`, `delta_q`, `lr_q`, `neg_step`, all `weight_out` and all `input_grad` to 0, and drops `busy` and `done` to 0. A partial pass is discarded, not resumed.

## Timing
- **Reset values:**
  - `weight_out[*]` = 32'h0 and `input_grad[*]` = 32'h0.
  - `busy` = 0, `done` = 0, state = IDLE.
- **Cycle sequence** (edge 0 = the edge sampling `start`=1 in IDLE):
  - Edge 0: state becomes SCALE; `busy`=1 from this edge.
  - Edge 1: `neg_step` is registered.
  - Edges 2 … INPUT_SIZE+1: `weight_out[k]` and `input_grad[k]` are updated at edge k+2.
  - Edge INPUT_SIZE+1: state becomes DONE; `done`=1 and `busy`=0 after this edge.
  - Edge INPUT_SIZE+2: state becomes IDLE; `done` returns to 0.
- **Latency:** start-to-done is INPUT_SIZE+1 edges. Minimum start-to-start period is INPUT_SIZE+3 cycles.
- **Output validity:** `weight_out`/`input_grad` are all valid and stable from the `done` cycle until the next accepted `start` plus 2 edges.
- **FMA path:** the FMA datapath is combinational between registers, so the single-cycle path is weight/input mux → FMA → output register.

## Test plan
- **Basic pass** (INPUT_SIZE=4; lr=0.5=32'h3F000000, delta=2.0=32'h40000000; all weights and inputs 1.0=32'h3F800000):
  - `neg_step`=32'hBF800000.
  - Every `weight_out`=32'h00000000 and every `input_grad`=32'h40000000.
  - `done` pulses exactly at edge 5 (one cycle wide).
- **Index mapping** (weight[i]=i+1 in fp32, input_data[i]=1.0, lr=1.0, delta=1.0):
  - `input_grad`={1,2,3,4}.
  - `weight_out`={0,1,2,3} (32'h0, 3F800000, 40000000, 40400000).
  - Each element appears at its stated edge and earlier entries hold their values.
- **Ignored start:** pulse `start` again at edge 2 with delta=32'hC0000000.
  - Results are identical to the basic pass.
  - Only one `done` pulse occurs; `delta_q` is unchanged.
- **Back-to-back:** hold `start`=1 continuously.
  - Passes begin every INPUT_SIZE+3 cycles.
  - `done` pulses are spaced by the same interval; `busy`=0 only in DONE/IDLE.
- **Reset mid-UPDATE:** assert `rst_n`=0 asynchronously at edge 3 plus ½ cycle.
  - All outputs are 0 immediately and `busy`=0; no `done` pulse occurs.
  - A fresh `start` after release completes normally.
- **Zero delta** (delta=0):
  - Every `input_grad`=32'h0 (sign per fma).
  - `weight_out[i]` equals `weight[i]` bit-exactly for finite weights.

Source files
------------

// File: rtl/fc_backward_update_if.sv
// Bundle of the control and data signals between fc_backward_update and its user.
// start is sampled only while idle. busy covers SCALE/UPDATE, done pulses once per pass.
// input_data/weight must hold from start until done.
interface fc_backward_update_if #(parameter int INPUT_SIZE = 32);
   logic                        start;
   logic [31:0]                 delta;
   logic [31:0]                 learning_rate;
   logic [INPUT_SIZE-1:0][31:0] input_data;
   logic [INPUT_SIZE-1:0][31:0] weight;
   logic [INPUT_SIZE-1:0][31:0] weight_out;
   logic [INPUT_SIZE-1:0][31:0] input_grad;
   logic                        busy;
   logic                        done;
   logic [1:0]                  state_dbg;

   modport master (
      output start, delta, learning_rate, input_data, weight,
      input  weight_out, input_grad, busy, done, state_dbg
   );

   modport slave (
      input  start, delta, learning_rate, input_data, weight,
      output weight_out, input_grad, busy, done, state_dbg
   );
endinterface

// File: rtl/fc_backward_update.sv
// Backward pass and SGD weight update for one fully connected neuron, one element per cycle.
// Also holds the shared single-precision fused multiply-add (y = a + b*c, RNE, denormals flushed).
module fma #(
   parameter int EXT   = 15,
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] y
);
   localparam int N = 50 + EXT;
   localparam logic signed [11:0] EXT_S = 12'(EXT);

   logic               sa, sb, sc, sp;
   logic               a_zero, b_zero, c_zero, a_inf, p_inf, any_nan, a_big;
   logic [23:0]        ma, mb, mc;
   logic [47:0]        a48, p48, big48, small48;
   logic signed [11:0] ea, ep, ebig, e_res;
   logic [11:0]        d, lead_v;
   logic [N-1:0]       big_v, small_full, small_v, lost, mag, norm;
   logic [N:0]         diff;
   logic               s_big, s_small, s_res, g, st, inc;
   logic [24:0]        mant_r;
   logic [22:0]        frac;
   logic [31:0]        r;
   int                 lead;

   always_comb begin
      sa      = a[31];
      sb      = b[31];
      sc      = c[31];
      sp      = sb ^ sc;
      a_zero  = (a[30:23] == 8'd0);
      b_zero  = (b[30:23] == 8'd0);
      c_zero  = (c[30:23] == 8'd0);
      a_inf   = (a[30:23] == 8'hFF);
      p_inf   = (b[30:23] == 8'hFF) || (c[30:23] == 8'hFF);
      any_nan = ((a[30:23] == 8'hFF) && (a[22:0] != 23'd0)) ||
                ((b[30:23] == 8'hFF) && (b[22:0] != 23'd0)) ||
                ((c[30:23] == 8'hFF) && (c[22:0] != 23'd0)) ||
                (p_inf && (b_zero || c_zero)) ||
                (a_inf && p_inf && (sa != sp));
      ma  = {1'b1, a[22:0]};
      mb  = {1'b1, b[22:0]};
      mc  = {1'b1, c[22:0]};
      a48 = {1'b0, ma, 23'd0};
      p48 = 48'(mb) * 48'(mc);
      ea  = $signed({4'd0, a[30:23]}) - 12'sd127;
      ep  = $signed({4'd0, b[30:23]}) + $signed({4'd0, c[30:23]}) - 12'sd254;

      // Both operands sit on a 48-bit grid whose LSB weight is exponent-46 of the larger one.
      a_big = !a_zero && (ea >= ep);
      if (a_big) begin
         ebig    = ea;
         big48   = a48;
         small48 = p48;
         s_big   = sa;
         s_small = sp;
         d       = ea - ep;
      end else begin
         ebig    = ep;
         big48   = p48;
         small48 = a_zero ? 48'd0 : a48;
         s_big   = sp;
         s_small = sa;
         d       = ep - ea;
      end
      big_v      = {2'b00, big48, {EXT{1'b0}}};
      small_full = {2'b00, small48, {EXT{1'b0}}};
      small_v    = small_full >> d;
      lost       = small_full & ~({N{1'b1}} << d);
      small_v[0] = small_v[0] | (|lost);

      s_res = s_big;
      if (s_big == s_small) begin
         diff = {1'b0, big_v} + {1'b0, small_v};
      end else begin
         diff = {1'b0, big_v} - {1'b0, small_v};
         if (diff[N]) begin
            diff  = -diff;
            s_res = s_small;
         end
      end
      mag = diff[N-1:0];

      lead = 0;
      for (int i = 0; i < N; i++) begin
         if (mag[i]) lead = i;
      end
      norm   = mag << (N - 1 - lead);
      mant_r = {1'b0, norm[N-1 -: 24]};
      g      = norm[N-25];
      st     = |norm[N-26:0];
      inc    = g & (st | mant_r[0]);
      mant_r = mant_r + {24'd0, inc};
      lead_v = 12'(lead);
      e_res  = ebig + $signed(lead_v) - 12'sd46 - EXT_S + (mant_r[24] ? 12'sd1 : 12'sd0) + 12'sd127;
      frac   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

      if (mag == '0)                r = 32'd0;
      else if (e_res >= 12'sd255)   r = {s_res, 8'hFF, 23'd0};
      else if (e_res <= 12'sd0)     r = {s_res, 31'd0};
      else                          r = {s_res, e_res[7:0], frac};

      if (any_nan)                  r = 32'h7FC0_0000;
      else if (a_inf)               r = a[31:0];
      else if (p_inf)               r = {sp, 8'hFF, 23'd0};
      else if (b_zero || c_zero)    r = a_zero ? {sa & sp, 31'd0} : a[31:0];
      y = r;
   end
endmodule

module fc_backward_update #(
   parameter int INPUT_SIZE = 32
) (
   input logic                 clk,
   input logic                 rst_n,
   fc_backward_update_if.slave bus
);
   localparam int IDX_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_SIZE - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, SCALE = 2'd1, UPDATE = 2'd2, DONE = 2'd3} state_t;

   state_t                      state_q, state_d;
   logic [IDX_W-1:0]            idx;
   logic [31:0]                 delta_q, lr_q, neg_step;
   logic [INPUT_SIZE-1:0][31:0] wout_q, grad_q;
   logic [31:0]                 grad_b, grad_y, upd_y;
   logic                        busy_c, done_c;

   always_comb begin
      state_d = state_q;
      busy_c  = 1'b0;
      done_c  = 1'b0;
      case (state_q)
         IDLE:    if (bus.start) state_d = SCALE;
         SCALE:   begin busy_c = 1'b1; state_d = UPDATE; end
         UPDATE:  begin busy_c = 1'b1; if (idx == LAST_IDX) state_d = DONE; end
         DONE:    begin done_c = 1'b1; state_d = IDLE; end
         default: state_d = IDLE;
      endcase
   end

   // The gradient FMA doubles as the -lr*delta scaler during SCALE; the sign flip is a bit inversion.
   assign grad_b = (state_q == SCALE) ? {~lr_q[31], lr_q[30:0]} : bus.weight[idx];

   fma #(15, 32) u_grad_fma (.a(32'd0),           .b(grad_b),   .c(delta_q),             .y(grad_y));
   fma #(15, 32) u_upd_fma  (.a(bus.weight[idx]), .b(neg_step), .c(bus.input_data[idx]), .y(upd_y));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx      <= '0;
         delta_q  <= '0;
         lr_q     <= '0;
         neg_step <= '0;
         wout_q   <= '0;
         grad_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: if (bus.start) begin
               delta_q <= bus.delta;
               lr_q    <= bus.learning_rate;
               idx     <= '0;
            end
            SCALE: neg_step <= grad_y;
            UPDATE: begin
               grad_q[idx] <= grad_y;
               wout_q[idx] <= upd_y;
               idx         <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.weight_out = wout_q;
   assign bus.input_grad = grad_q;
   assign bus.busy       = busy_c;
   assign bus.done       = done_c;
   assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_fc_backward_update.sv
// Directed and randomized checks of fc_backward_update against a real-arithmetic reference.
// Random operands are short dyadic values so every exact result fits in single precision.
module tb_fc_backward_update;
   localparam int N_IN = 4;
   localparam int VW   = 32 * N_IN;

   logic          clk;
   logic          rst_n;
   int            n_assert = 0;
   int            n_fail   = 0;
   logic [31:0]   m_grad [N_IN];
   logic [31:0]   m_wout [N_IN];
   logic [VW-1:0] exp_q [$];

   fc_backward_update_if #(.INPUT_SIZE(N_IN)) bus ();
   fc_backward_update #(.INPUT_SIZE(N_IN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   // clock / watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, required finish before 200000 ns");
      $fatal(1, "watchdog expired");
   end

   // reference arithmetic helpers
   function automatic real f2r(input logic [31:0] f);
      logic [63:0] dbits;
      if (f[30:23] == 8'd0) dbits = {f[31], 63'd0};
      else dbits = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
      return $bitstoreal(dbits);
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] dbits;
      dbits = $realtobits(r);
      if (dbits[62:0] == 63'd0) return {dbits[63], 31'd0};
      return {dbits[63], 8'(dbits[62:52] - 11'd896), dbits[51:29]};
   endfunction

   function automatic logic [31:0] rand_fp(input bit positive);
      real r;
      int  e;
      r = real'($urandom_range(1, 7));
      e = int'($urandom_range(0, 4));
      for (int i = 0; i < e; i++) r = r * 2.0;
      r = r / 4.0;
      if (!positive && ($urandom_range(0, 1) == 1)) r = -r;
      return r2f(r);
   endfunction

   function automatic logic [VW-1:0] pack(input logic [31:0] v [N_IN]);
      logic [VW-1:0] p;
      for (int k = 0; k < N_IN; k++) p[32*k +: 32] = v[k];
      return p;
   endfunction

   // scoreboard
   task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic clear_model();
      for (int k = 0; k < N_IN; k++) begin
         m_grad[k] = 32'd0;
         m_wout[k] = 32'd0;
      end
   endtask

   // drivers
   task automatic set_ones();
      for (int k = 0; k < N_IN; k++) begin
         bus.weight[k]     = 32'h3F80_0000;
         bus.input_data[k] = 32'h3F80_0000;
      end
   endtask

   task automatic set_random();
      for (int k = 0; k < N_IN; k++) begin
         bus.weight[k]     = rand_fp(1'b0);
         bus.input_data[k] = rand_fp(1'b0);
      end
   endtask

   task automatic idle_check(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         check("idle_busy", VW'(bus.busy), VW'(1'b0));
         check("idle_done", VW'(bus.done), VW'(1'b0));
      end
   endtask

   // One pass from the edge that accepts start to the edge that returns to IDLE.
   task automatic run_pass(input logic [31:0] dl, input logic [31:0] lr, input bit poke, input bit hold);
      logic [31:0] fg [N_IN];
      logic [31:0] fw [N_IN];
      logic [31:0] exp_neg;
      real         neg;
      neg     = 0.0 + (-f2r(lr)) * f2r(dl);
      exp_neg = r2f(neg);
      for (int k = 0; k < N_IN; k++) begin
         fg[k] = r2f(0.0 + f2r(bus.weight[k]) * f2r(dl));
         fw[k] = r2f(f2r(bus.weight[k]) + neg * f2r(bus.input_data[k]));
      end
      exp_q.push_back(pack(fg));
      exp_q.push_back(pack(fw));
      bus.delta         = dl;
      bus.learning_rate = lr;
      bus.start         = 1'b1;
      for (int m = 0; m <= N_IN + 2; m++) begin
         @(negedge clk);
         if (!hold) bus.start = 1'b0;
         if (poke && m == 1) begin bus.start = 1'b1; bus.delta = 32'hC000_0000; end
         if (poke && m == 2) begin bus.start = 1'b0; bus.delta = dl; end
         if (m >= 2 && m <= N_IN + 1) begin
            m_grad[m-2] = fg[m-2];
            m_wout[m-2] = fw[m-2];
         end
         check("busy", VW'(bus.busy), VW'(m <= N_IN));
         check("done", VW'(bus.done), VW'(m == N_IN + 1));
         check("input_grad", bus.input_grad, pack(m_grad));
         check("weight_out", bus.weight_out, pack(m_wout));
         if (m == 1) check("neg_step", VW'(dut.neg_step), VW'(exp_neg));
         if (poke && m >= 2) check("delta_q_kept", VW'(dut.delta_q), VW'(dl));
         if (m == N_IN + 1) begin
            check("final_grad", bus.input_grad, exp_q.pop_front());
            check("final_wout", bus.weight_out, exp_q.pop_front());
         end
      end
   endtask

   // main sequence
   initial begin
      rst_n             = 1'b0;
      bus.start         = 1'b0;
      bus.delta         = 32'd0;
      bus.learning_rate = 32'd0;
      bus.weight        = '0;
      bus.input_data    = '0;
      clear_model();
      repeat (2) @(negedge clk);
      check("reset_wout", bus.weight_out, '0);
      check("reset_grad", bus.input_grad, '0);
      check("reset_busy", VW'(bus.busy), VW'(1'b0));
      check("reset_done", VW'(bus.done), VW'(1'b0));
      rst_n = 1'b1;
      idle_check(2);

      // basic pass
      set_ones();
      run_pass(32'h4000_0000, 32'h3F00_0000, 1'b0, 1'b0);
      check("basic_wout", bus.weight_out, {N_IN{32'h0000_0000}});
      check("basic_grad", bus.input_grad, {N_IN{32'h4000_0000}});

      // index mapping
      for (int k = 0; k < N_IN; k++) begin
         bus.weight[k]     = r2f(real'(k + 1));
         bus.input_data[k] = 32'h3F80_0000;
      end
      run_pass(32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0);
      check("index_grad", bus.input_grad, {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000});
      check("index_wout", bus.weight_out, {32'h4040_0000, 32'h4000_0000, 32'h3F80_0000, 32'h0000_0000});

      // start while busy is ignored
      set_ones();
      run_pass(32'h4000_0000, 32'h3F00_0000, 1'b1, 1'b0);
      check("ignored_wout", bus.weight_out, {N_IN{32'h0000_0000}});
      check("ignored_grad", bus.input_grad, {N_IN{32'h4000_0000}});
      idle_check(3);

      // zero delta leaves weights untouched
      set_random();
      run_pass(32'h0000_0000, rand_fp(1'b1), 1'b0, 1'b0);
      check("zero_delta_wout", bus.weight_out, bus.weight);

      // random passes
      for (int t = 0; t < 4; t++) begin
         set_random();
         run_pass(rand_fp(1'b0), rand_fp(1'b1), 1'b0, 1'b0);
         idle_check(1);
      end

      // back-to-back with start held high
      for (int t = 0; t < 3; t++) begin
         set_random();
         run_pass(rand_fp(1'b0), rand_fp(1'b1), 1'b0, 1'b1);
      end
      bus.start = 1'b0;
      idle_check(2);

      // reset during UPDATE
      set_random();
      bus.delta         = rand_fp(1'b0);
      bus.learning_rate = rand_fp(1'b1);
      bus.start         = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      clear_model();
      check("midrst_wout", bus.weight_out, '0);
      check("midrst_grad", bus.input_grad, '0);
      check("midrst_busy", VW'(bus.busy), VW'(1'b0));
      check("midrst_done", VW'(bus.done), VW'(1'b0));
      check("midrst_neg_step", VW'(dut.neg_step), '0);
      idle_check(3);
      rst_n = 1'b1;
      idle_check(1);
      set_random();
      run_pass(rand_fp(1'b0), rand_fp(1'b1), 1'b0, 1'b0);
      idle_check(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
